// File: rtl/seg7_driver.sv
// seg7_driver: pin driver for a 4-digit multiplexed 7-segment display.
// Takes the scan multiplexer's nibble and active-low select, and registers
// hex decode, decimal point, anti-ghosting blanking and PWM dimming onto the pins.
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking for digits 3..1.
module seg7_driver #(
    parameter int BLANK_CYC = 2,
    parameter int BR_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      digit,
    input  logic [3:0]      anode_in,
    input  logic [3:0]      dp_mask,
    input  logic [BR_W-1:0] bright,
    output logic [6:0]      seg,
    output logic            dp,
    output logic [3:0]      anode
);

    // The blank counter must hold BLANK_CYC; keep at least one bit so BLANK_CYC=0 still elaborates.
    localparam int            CW       = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC);

    logic [3:0]      a_q;
    logic [3:0]      d_q;
    logic [CW-1:0]   blank_cnt;
    logic [BR_W-1:0] pwm_cnt;
    logic            lit;
    logic            valid;
    logic [1:0]      idx;
    logic [6:0]      seg_dec;
    logic            lz_sup;
    logic            dark;

    // Stage 1: capture select/nibble and restart the blank window whenever the select moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= 4'b1111;
            d_q       <= 4'h0;
            blank_cnt <= '0;
        end else begin
            a_q <= anode_in;
            d_q <= digit;
            if (anode_in != a_q) begin
                blank_cnt <= BLANK_LD;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
        end
    end

    // Free-running PWM phase counter; wraps naturally at 2^BR_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Select validity and digit index: exactly one zero bit is a real digit.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        case (a_q)
            4'b0111: begin valid = 1'b1; idx = 2'd3; end
            4'b1011: begin valid = 1'b1; idx = 2'd2; end
            4'b1101: begin valid = 1'b1; idx = 2'd1; end
            4'b1110: begin valid = 1'b1; idx = 2'd0; end
            default: begin valid = 1'b0; idx = 2'd0; end
        endcase
    end

    // Brightness gate: all-ones is forced full-on so it never drops a PWM slot.
    always_comb begin
        lit = (bright == {BR_W{1'b1}}) || (pwm_cnt < bright);
    end

    // Hex to active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_dec = 7'b1111111;
        case (d_q)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'b1111111;
        endcase
    end

`ifdef SEG7_LZB_EN
    logic lz_run;

    // Leading-zero run: armed by a zero on digit 3, carried while digits 2 and 1 stay zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lz_run <= 1'b0;
        end else if (valid) begin
            if (idx == 2'd3) begin
                lz_run <= (d_q == 4'h0);
            end else if (d_q != 4'h0) begin
                lz_run <= 1'b0;
            end
        end
    end

    // Suppress segments of a leading zero; digit 0 always shows.
    always_comb begin
        lz_sup = (idx != 2'd0) && (d_q == 4'h0) && ((idx == 2'd3) || lz_run);
    end
`else
    // Leading-zero blanking not built: every digit decodes normally.
    always_comb begin
        lz_sup = 1'b0;
    end
`endif

    // Pins are dark while blanking, outside the PWM on-phase, or with a bad select.
    always_comb begin
        dark = (blank_cnt != '0) || !lit || !valid;
    end

    // Stage 2: registered pin drivers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else if (dark) begin
            anode <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            anode <= a_q;
            seg   <= lz_sup ? 7'b1111111 : seg_dec;
            dp    <= ~dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_seg7_driver.sv
// Directed testbench for seg7_driver (BLANK_CYC=2, BR_W=4).
module tb_seg7_driver;

    logic       clk;
    logic       reset;
    logic [3:0] digit;
    logic [3:0] anode_in;
    logic [3:0] dp_mask;
    logic [3:0] bright;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] anode;

    int tests;
    int fails;

    seg7_driver #(.BLANK_CYC(2), .BR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .digit    (digit),
        .anode_in (anode_in),
        .dp_mask  (dp_mask),
        .bright   (bright),
        .seg      (seg),
        .dp       (dp),
        .anode    (anode)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            digit    = 4'($urandom);
            anode_in = 4'($urandom);
            dp_mask  = 4'($urandom);
            bright   = 4'($urandom);
            step();
            tests++;
            if ({anode, seg, dp} !== 12'hFFF) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got anode=%b seg=%b dp=%b, want 1111/1111111/1", i, anode, seg, dp);
            end
        end
        anode_in = 4'b1110; digit = 4'h8; bright = 4'hF; dp_mask = 4'b0000;
        step();
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            tests++;
            if ({anode, seg, dp} !== 12'hFFF) begin
                fails++;
                $display("FAIL reset_release_dark[%0d]: got anode=%b seg=%b dp=%b, want dark", e, anode, seg, dp);
            end
        end
        step();
        tests++;
        if (anode !== 4'b1110 || seg !== 7'b0000000 || dp !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_digit: got anode=%b seg=%b dp=%b, want 1110/0000000/1", anode, seg, dp);
        end
    endtask

    task automatic test_decode();
        for (int j = 0; j <= 16; j++) begin
            if (j < 16) digit = 4'(j);
            step();
            if (j >= 1) begin
                tests++;
                if (seg !== seg_ref(4'(j - 1)) || anode !== 4'b1110) begin
                    fails++;
                    $display("FAIL decode[%h]: got anode=%b seg=%b, want 1110/%b", j - 1, anode, seg, seg_ref(4'(j - 1)));
                end
            end
        end
    endtask

    task automatic test_blanking();
        anode_in = 4'b1101; digit = 4'h5;
        step();
        for (int e = 1; e <= 2; e++) begin
            step();
            tests++;
            if ({anode, seg, dp} !== 12'hFFF) begin
                fails++;
                $display("FAIL blank_single[k+%0d]: got anode=%b seg=%b dp=%b, want dark", e, anode, seg, dp);
            end
        end
        step();
        tests++;
        if (anode !== 4'b1101 || seg !== 7'b0010010) begin
            fails++;
            $display("FAIL blank_single_show: got anode=%b seg=%b, want 1101/0010010", anode, seg);
        end
        anode_in = 4'b1011;
        step();
        anode_in = 4'b0111;
        for (int e = 1; e <= 3; e++) begin
            step();
            tests++;
            if ({anode, seg, dp} !== 12'hFFF) begin
                fails++;
                $display("FAIL blank_double[k+%0d]: got anode=%b seg=%b dp=%b, want dark", e, anode, seg, dp);
            end
        end
        step();
        tests++;
        if (anode !== 4'b0111 || seg !== 7'b0010010) begin
            fails++;
            $display("FAIL blank_double_show: got anode=%b seg=%b, want 0111/0010010", anode, seg);
        end
        digit = 4'h3;
        step();
        tests++;
        if (anode !== 4'b0111 || seg !== 7'b0010010) begin
            fails++;
            $display("FAIL digit_change_noblank1: got anode=%b seg=%b, want 0111/0010010", anode, seg);
        end
        step();
        tests++;
        if (anode !== 4'b0111 || seg !== 7'b0110000) begin
            fails++;
            $display("FAIL digit_change_noblank2: got anode=%b seg=%b, want 0111/0110000", anode, seg);
        end
    endtask

    task automatic test_pwm();
        logic [3:0] levels [3];
        int         want   [3];
        int         on_cnt;
        levels[0] = 4'd4;  want[0] = 4;
        levels[1] = 4'd0;  want[1] = 0;
        levels[2] = 4'hF;  want[2] = 16;
        for (int l = 0; l < 3; l++) begin
            bright = levels[l];
            step();
            on_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (anode !== 4'b1111) on_cnt++;
            end
            tests++;
            if (on_cnt != want[l]) begin
                fails++;
                $display("FAIL pwm_bright_%0d: got %0d lit cycles of 16, want %0d", levels[l], on_cnt, want[l]);
            end
        end
    endtask

    task automatic test_dp_invalid();
        bright = 4'hF; dp_mask = 4'b0100;
        anode_in = 4'b1011; digit = 4'h1;
        repeat (4) step();
        tests++;
        if (anode !== 4'b1011 || dp !== 1'b0 || seg !== 7'b1111001) begin
            fails++;
            $display("FAIL dp_lit: got anode=%b seg=%b dp=%b, want 1011/1111001/0", anode, seg, dp);
        end
        anode_in = 4'b1110;
        repeat (4) step();
        tests++;
        if (anode !== 4'b1110 || dp !== 1'b1) begin
            fails++;
            $display("FAIL dp_off: got anode=%b dp=%b, want 1110/1", anode, dp);
        end
        anode_in = 4'b1111;
        repeat (4) step();
        tests++;
        if ({anode, seg, dp} !== 12'hFFF) begin
            fails++;
            $display("FAIL invalid_1111: got anode=%b seg=%b dp=%b, want dark", anode, seg, dp);
        end
        anode_in = 4'b0011;
        repeat (4) step();
        tests++;
        if ({anode, seg, dp} !== 12'hFFF) begin
            fails++;
            $display("FAIL invalid_0011: got anode=%b seg=%b dp=%b, want dark", anode, seg, dp);
        end
    endtask

`ifdef SEG7_LZB_EN
    task automatic test_lzb();
        logic [3:0]  sel  [4];
        logic [15:0] data [2];
        logic [6:0]  want [2][4];
        sel[0] = 4'b0111; sel[1] = 4'b1011; sel[2] = 4'b1101; sel[3] = 4'b1110;
        data[0] = 16'h0070; data[1] = 16'h0000;
        want[0][0] = 7'b1111111; want[0][1] = 7'b1111111;
        want[0][2] = 7'b1111000; want[0][3] = 7'b1000000;
        want[1][0] = 7'b1111111; want[1][1] = 7'b1111111;
        want[1][2] = 7'b1111111; want[1][3] = 7'b1000000;
        bright = 4'hF; dp_mask = 4'b0000;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 4; s++) begin
                anode_in = sel[s];
                digit    = data[p][4*(3-s) +: 4];
                repeat (4) step();
                tests++;
                if (anode !== sel[s] || seg !== want[p][s]) begin
                    fails++;
                    $display("FAIL lzb[%h idx%0d]: got anode=%b seg=%b, want %b/%b", data[p], 3 - s, anode, seg, sel[s], want[p][s]);
                end
            end
        end
    endtask
`endif

    initial begin
        clk = 1'b0; reset = 1'b0;
        digit = 4'h0; anode_in = 4'b1111; dp_mask = 4'h0; bright = 4'h0;
        tests = 0; fails = 0;
        test_reset();
        test_decode();
        test_blanking();
        test_pwm();
        test_dp_invalid();
`ifdef SEG7_LZB_EN
        test_lzb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
